note_player: RTL and testbench

//   Responder side of the new_note / note_done handshake used by the music player control FSM.
//   - On a new_note pulse: latches the note and its duration.
//   - While the note plays: counts duration down on beat ticks and runs a phase accumulator

---
 rtl/note_player.sv | 120 ++++++++++++
 tb/tb_note_player.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// Note player: responder side of the new_note / note_done handshake.
// Latches a note, counts its duration down on beat ticks and runs the phase accumulator for the sine lookup.
module note_player #(
    parameter int NOTE_W  = 6,
    parameter int DUR_W   = 6,
    parameter int PHASE_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               new_note,
    input  logic [NOTE_W-1:0]  note_in,
    input  logic [DUR_W-1:0]   duration_in,
    input  logic               beat,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] step_in,
    output logic               note_done,
    output logic               note_active,
    output logic [NOTE_W-1:0]  note_out,
    output logic [PHASE_W-1:0] phase
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [NOTE_W-1:0]  note_reg, note_next;
    logic [DUR_W-1:0]   count_reg, count_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               load;

    assign load = new_note & play;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            note_reg  <= '0;
            count_reg <= '0;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            note_reg  <= note_next;
            count_reg <= count_next;
            phase_reg <= phase_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        note_next  = note_reg;
        count_next = count_reg;
        phase_next = phase_reg;

        case (state_reg)
            IDLE: begin
                phase_next = '0;
                if (load) begin
                    state_next = PLAYING;
                    note_next  = note_in;
                    count_next = duration_in;
                end
            end

            PLAYING: begin
                if (!play) begin
                    state_next = IDLE;
                    count_next = '0;
                    phase_next = '0;
                end else if (new_note) begin
                    // Restart takes priority over any beat or expiry in the same cycle.
                    note_next  = note_in;
                    count_next = duration_in;
                    phase_next = '0;
                end else if (count_reg == '0) begin
                    state_next = DONE;
                    phase_next = '0;
                end else begin
                    if (beat) begin
                        count_next = count_reg - DUR_W'(1);
                        if (count_reg == DUR_W'(1)) begin
                            state_next = DONE;
                        end
                    end
                    if (state_next != PLAYING || note_reg == '0) begin
                        phase_next = '0;
                    end else if (sample_tick) begin
                        phase_next = phase_reg + step_in;
                    end
                end
            end

            DONE: begin
                // The done pulse is always emitted; a concurrent load goes straight back to playing.
                phase_next = '0;
                if (load) begin
                    state_next = PLAYING;
                    note_next  = note_in;
                    count_next = duration_in;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
                phase_next = '0;
            end
        endcase
    end

    assign note_done   = (state_reg == DONE);
    assign note_active = (state_reg == PLAYING);
    assign note_out    = note_reg;
    assign phase       = phase_reg;

endmodule

// File: tb/tb_note_player.sv
// Testbench for note_player: directed scenarios plus randomized traffic checked
// against a beat-counting reference model.
module tb_note_player;

    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int PHASE_W = 20;
    localparam longint PHASE_MOD = 64'd1 << PHASE_W;

    logic               clk;
    logic               reset;
    logic               play;
    logic               new_note;
    logic [NOTE_W-1:0]  note_in;
    logic [DUR_W-1:0]   duration_in;
    logic               beat;
    logic               sample_tick;
    logic [PHASE_W-1:0] step_in;
    logic               note_done;
    logic               note_active;
    logic [NOTE_W-1:0]  note_out;
    logic [PHASE_W-1:0] phase;

    note_player #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .PHASE_W(PHASE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .new_note    (new_note),
        .note_in     (note_in),
        .duration_in (duration_in),
        .beat        (beat),
        .sample_tick (sample_tick),
        .step_in     (step_in),
        .note_done   (note_done),
        .note_active (note_active),
        .note_out    (note_out),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a note is "sounding" with beats_left remaining,
    // or has just finished (done_now), or nothing is happening.
    bit     m_sounding;
    bit     m_done_now;
    int     m_beats_left;
    int     m_note;
    longint m_phase;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sounding   = 0;
        m_done_now   = 0;
        m_beats_left = 0;
        m_note       = 0;
        m_phase      = 0;
    endtask

    task automatic model_start();
        m_sounding   = 1;
        m_note       = int'(note_in);
        m_beats_left = int'(duration_in);
        m_phase      = 0;
    endtask

    task automatic model_finish();
        m_sounding = 0;
        m_done_now = 1;
        m_phase    = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (m_done_now) begin
            m_done_now = 0;
            if (new_note && play) model_start();
        end else if (m_sounding) begin
            if (!play) begin
                m_sounding   = 0;
                m_beats_left = 0;
                m_phase      = 0;
            end else if (new_note) begin
                model_start();
            end else if (m_beats_left == 0) begin
                model_finish();
            end else begin
                if (beat) m_beats_left = m_beats_left - 1;
                if (beat && m_beats_left == 0) begin
                    model_finish();
                end else if (m_note == 0) begin
                    m_phase = 0;
                end else if (sample_tick) begin
                    m_phase = (m_phase + longint'(step_in)) % PHASE_MOD;
                end
            end
        end else if (new_note && play) begin
            model_start();
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".done"},   32'(note_done),   32'(m_done_now));
        check({tag, ".active"}, 32'(note_active), 32'(m_sounding));
        check({tag, ".note"},   32'(note_out),    32'(m_note));
        check({tag, ".phase"},  32'(phase),       32'(m_phase));
    endtask

    task automatic drive(input bit p, input bit nn, input int nt, input int dur,
                         input bit bt, input bit st, input int stp);
        play        = p;
        new_note    = nn;
        note_in     = NOTE_W'(nt);
        duration_in = DUR_W'(dur);
        beat        = bt;
        sample_tick = st;
        step_in     = PHASE_W'(stp);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            tick(tag);
        end
    endtask

    int done_cnt;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        reset = 1'b1;
        idle_cycles(2, "post_reset");

        // Test 2: 3-beat note, beats 10 cycles apart.
        $display("test2: note 12 dur 3");
        drive(1, 1, 12, 3, 0, 0, 0);
        tick("t2_load");
        check("t2_active_next", 32'(note_active), 32'd1);
        done_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 9; i++) begin
                drive(1, 0, 0, 0, 0, 1, 'h1234);
                tick("t2_wait");
                done_cnt += int'(note_done);
            end
            drive(1, 0, 0, 0, 1, 0, 0);
            tick("t2_beat");
            done_cnt += int'(note_done);
        end
        check("t2_done_after_beat3", 32'(note_done), 32'd1);
        idle_cycles(1, "t2_tail");
        check("t2_done_width", 32'(note_done), 32'd0);
        check("t2_done_count", 32'(done_cnt), 32'd1);

        // Test 3: zero-duration note finishes without a beat.
        $display("test3: zero duration");
        drive(1, 1, 7, 0, 0, 0, 0);
        tick("t3_load");
        idle_cycles(1, "t3_wait");
        check("t3_done_2cyc", 32'(note_done), 32'd1);
        idle_cycles(2, "t3_tail");

        // Test 4: play dropped after one of four beats.
        $display("test4: abort via play");
        drive(1, 1, 9, 4, 0, 0, 0);
        tick("t4_load");
        drive(1, 0, 0, 0, 1, 1, 'h3000);
        tick("t4_beat");
        drive(0, 0, 0, 0, 0, 1, 'h3000);
        tick("t4_stop");
        check("t4_inactive", 32'(note_active), 32'd0);
        check("t4_phase0", 32'(phase), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1, 1, 'h3000);
            tick("t4_idle");
            done_cnt += int'(note_done);
        end
        check("t4_no_done", 32'(done_cnt), 32'd0);

        // Test 5: phase wrap, then rest note.
        $display("test5: phase wrap");
        drive(1, 1, 5, 4, 0, 0, 0);
        tick("t5_load");
        drive(1, 0, 0, 0, 0, 1, 'hF0000);
        tick("t5_st1");
        tick("t5_st2");
        check("t5_wrap", 32'(phase), 32'h000E0000);
        drive(1, 1, 0, 4, 0, 0, 0);
        tick("t5_rest_load");
        drive(1, 0, 0, 0, 0, 1, 'hF0000);
        tick("t5_rest1");
        tick("t5_rest2");
        check("t5_rest_phase", 32'(phase), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("t5_stop");

        // Test 6: reload coinciding with the expiring beat.
        $display("test6: reload wins over beat");
        drive(1, 1, 20, 2, 0, 0, 0);
        tick("t6_load");
        drive(1, 0, 0, 0, 1, 0, 0);
        tick("t6_beat1");
        drive(1, 1, 21, 2, 1, 0, 0);
        tick("t6_reload");
        check("t6_no_done", 32'(note_done), 32'd0);
        idle_cycles(3, "t6_gap");
        drive(1, 0, 0, 0, 1, 0, 0);
        tick("t6_b1");
        check("t6_still_active", 32'(note_active), 32'd1);
        tick("t6_b2");
        check("t6_done", 32'(note_done), 32'd1);
        idle_cycles(2, "t6_tail");

        // Test 1: async reset mid-note.
        $display("test1: async reset mid-play");
        drive(1, 1, 3, 5, 0, 0, 0);
        tick("t1_load");
        drive(1, 0, 0, 0, 1, 1, 'h1111);
        tick("t1_b1");
        tick("t1_b2");
        check("t1_phase_nz", 32'(phase != 0), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("t1_async");
        @(negedge clk);
        check_outputs("t1_held");
        reset = 1'b1;
        idle_cycles(2, "t1_after");

        // Randomized traffic.
        $display("random: start");
        for (int i = 0; i < 3000; i++) begin
            bit p, nn, bt, st;
            int nt, dur;
            p   = ($urandom_range(99) < 93);
            nn  = ($urandom_range(99) < 6);
            bt  = ($urandom_range(99) < 20);
            st  = ($urandom_range(99) < 50);
            nt  = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(63, 1));
            dur = int'($urandom_range(5));
            drive(p, nn, nt, dur, bt, st, int'($urandom_range(PHASE_MOD - 1)));
            if (nn && p) $display("random: cycle %0d load note %0d dur %0d", i, nt, dur);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
